// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider with per-channel enable,
// glitch-free divisor update at the wrap, and a common synchronous restart.
module clk_div_multi #(
    parameter int NCH     = 2,
    parameter int WIDTH   = 19,
    parameter int DIV_RST = 50000,
    parameter int CHW     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic             sync_clr,
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [WIDTH-1:0] wr_data,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pend
);

    localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_RST);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic wr_ok;

    // Writes addressed past the last channel are dropped here, once for all channels.
    assign wr_ok = wr_en && (int'(wr_ch) < NCH);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] d_eff;
        logic             pend_r;
        logic             clk_r;
        logic             tick_r;
        logic             wrap;
        logic             hit;
        logic             apply;

        // A pending divisor is only swapped in where no phase is in flight:
        // at a wrap, while disabled, or on a restart.
        always_comb begin
            d_eff = (div == '0) ? ONE : div;
            wrap  = (cnt == d_eff - ONE);
            hit   = wr_ok && (wr_ch == CHW'(k));
            apply = pend_r && (sync_clr || !en[k] || wrap);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div    <= DIV_INIT;
                nxt    <= DIV_INIT;
                pend_r <= 1'b0;
                clk_r  <= 1'b1;
                tick_r <= 1'b0;
            end else begin
                if (sync_clr) begin
                    cnt    <= '0;
                    clk_r  <= 1'b1;
                    tick_r <= 1'b0;
                end else if (en[k]) begin
                    if (wrap) begin
                        cnt    <= '0;
                        tick_r <= 1'b1;
                        clk_r  <= ~clk_r;
                    end else begin
                        cnt    <= cnt + ONE;
                        tick_r <= 1'b0;
                    end
                end else begin
                    tick_r <= 1'b0;
                end

                if (apply) begin
                    div <= nxt;
                end

                // A write on the applying edge re-arms pend with the new value.
                if (hit) begin
                    nxt    <= wr_data;
                    pend_r <= 1'b1;
                end else if (apply) begin
                    pend_r <= 1'b0;
                end
            end
        end

        assign clk_out[k] = clk_r;
        assign tick[k]    = tick_r;
        assign pend[k]    = pend_r;
    end

endmodule
